intr_controller: RTL

//  Multi-source interrupt controller between peripheral event sources (uart_rx, timer, ...) and the cpu trap logic.

---
 rtl/intr_controller.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/intr_controller.sv
// intr_controller: multi-source interrupt controller.
// Event pulses are latched as pending bits and masked by an enable register.
// The lowest-numbered active source wins and is presented to the cpu as a
// trap request with a vector address. Further requests are held off until
// the handler returns with iret.
// Optional build macro INTC_VECTORED_EN: when defined, each source gets its
// own vector (vector_base + claim_id*VEC_STRIDE). When undefined, every
// source traps to vector_base and the handler reads CLAIM to dispatch.
//
// Handshake: irq_req stays high from the cycle the FSM enters REQ until the
// cycle after irq_take (accepted) or until the claimed source is no longer
// pending&enabled (withdrawn). irq_vector is valid whenever irq_req=1.
// irq_take and irq_ret are single-cycle strobes. A take outside REQ and a
// ret outside SERVICE are ignored, and a take wins over a simultaneous ret.
module intr_controller #(
  parameter int NUM_SRC    = 4,
  parameter int VEC_STRIDE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_evt,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               irq_req,
  output logic [31:0]        irq_vector,
  input  logic               irq_take,
  input  logic               irq_ret,
  output logic               in_service,
  output logic [1:0]         state_dbg
);

  // Elaboration-time range check on the parameters.
  if (NUM_SRC < 1 || NUM_SRC > 16 || VEC_STRIDE < 0) begin : g_bad_param
    $error("intr_controller: NUM_SRC must be 1..16 and VEC_STRIDE >= 0");
  end

  typedef logic [NUM_SRC-1:0] src_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_ACK    = 2'd0;
  localparam logic [1:0] ADDR_ENABLE = 2'd1;
  localparam logic [1:0] ADDR_VECTOR = 2'd2;
  localparam logic [1:0] ADDR_CLAIM  = 2'd3;

  state_t      state;
  state_t      state_nxt;
  src_t        pending;
  src_t        enable;
  logic [31:0] vector_base;
  logic [3:0]  claim_id;

  src_t        active;
  src_t        ack_clr;
  src_t        claim_mask;
  logic        any_active;
  logic        claim_live;
  logic [3:0]  winner;

  assign active     = pending & enable;
  assign any_active = |active;
  assign ack_clr    = (cfg_we && cfg_addr == ADDR_ACK) ? cfg_wdata[NUM_SRC-1:0] : '0;
  assign claim_mask = src_t'(1) << claim_id;
  assign claim_live = |(active & claim_mask);
  assign state_dbg  = state;

  // Fixed priority pick: lowest index among pending & enabled sources.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) winner = 4'(i);
    end
  end

  // Pending bits: a new event beats a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending & ~ack_clr) | src_evt;
  end

  // Configuration registers written from the cpu register port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable      <= '0;
      vector_base <= '0;
    end else if (cfg_we) begin
      if (cfg_addr == ADDR_ENABLE) enable      <= cfg_wdata[NUM_SRC-1:0];
      if (cfg_addr == ADDR_VECTOR) vector_base <= cfg_wdata;
    end
  end

  // Claim id is captured only when IDLE hands a winner over to REQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           claim_id <= '0;
    else if (state == ST_IDLE && any_active) claim_id <= winner;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state: take beats withdrawal; no re-arbitration inside REQ.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (any_active) state_nxt = ST_REQ;
      ST_REQ: begin
        if (irq_take)         state_nxt = ST_SERVICE;
        else if (!claim_live) state_nxt = ST_IDLE;
      end
      ST_SERVICE: if (irq_ret) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state so reset drops them at once.
  always_comb begin
    irq_req    = 1'b0;
    in_service = 1'b0;
    case (state)
      ST_REQ:     irq_req    = 1'b1;
      ST_SERVICE: in_service = 1'b1;
      default:    ;
    endcase
  end

`ifdef INTC_VECTORED_EN
  // Per-source vector table, 32-bit wrap-around.
  assign irq_vector = vector_base + (32'(claim_id) * 32'(VEC_STRIDE));
`else
  // Single shared entry point; the handler dispatches on CLAIM.
  assign irq_vector = vector_base;
`endif

  // Combinational register read-back.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_ACK:    cfg_rdata = 32'(pending);
      ADDR_ENABLE: cfg_rdata = 32'(enable);
      ADDR_VECTOR: cfg_rdata = vector_base;
      ADDR_CLAIM:  cfg_rdata = {28'd0, claim_id};
      default:     cfg_rdata = '0;
    endcase
  end

endmodule
